// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI memory controller.
//   sqi_io_mode_t : direction of the SIO pins (IN = SRAM drives, OUT = core drives)
//   sqi_state_t   : controller FSM states
//   SQI_OP_*      : 23LC512 sequential-mode opcodes, sent MSB nibble first
package idli_pkg;

    typedef enum logic {
        SQI_IO_IN  = 1'b0,
        SQI_IO_OUT = 1'b1
    } sqi_io_mode_t;

    typedef enum logic [2:0] {
        SQI_ST_IDLE  = 3'd0,
        SQI_ST_CMD   = 3'd1,
        SQI_ST_ADDR  = 3'd2,
        SQI_ST_DUMMY = 3'd3,
        SQI_ST_DATA  = 3'd4,
        SQI_ST_END   = 3'd5
    } sqi_state_t;

    localparam logic [7:0] SQI_OP_READ  = 8'h03;
    localparam logic [7:0] SQI_OP_WRITE = 8'h02;

    function automatic int sqi_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/idli_sqi_ctrl_m.sv
// SQI memory controller: turns core read/write burst requests into nibble-wide
// SQI transactions on a 23LC512-style serial SRAM in sequential mode.
//
// Ports
//   i_sqi_gck, i_sqi_rst_n        clock, synchronous active-low reset
//   i_sqi_req/_wr/_addr, o_sqi_ack burst request, accepted with a 1-cycle ack
//   i_sqi_stop, o_sqi_busy        end current burst / not idle
//   o_sqi_rdata/_rvld, i_sqi_racp read nibble stream
//   i_sqi_wdata/_wvld, o_sqi_wacp write nibble stream
//   o_sqi_sck, o_sqi_cs           SRAM clock, chip select (active-low)
//   o_sqi_io_mode, i/o_sqi_sio    SIO direction and pins
//
// state | meaning
// IDLE  | CS high, waiting for req
// CMD   | 2 opcode beats, SIO out
// ADDR  | ADDR_W/4 address beats, SIO out
// DUMMY | DUMMY_NIB turnaround beats (reads only), SIO in
// DATA  | nibble transfer, beat paced by wvld (write) or rvld/racp (read)
// END   | one cycle with CS high before returning to IDLE
//
// Every beat is phase A (SCK low, SIO updated) then phase B (SCK high).
module idli_sqi_ctrl_m
    import idli_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DUMMY_NIB = 2
) (
    input  logic              i_sqi_gck,
    input  logic              i_sqi_rst_n,
    input  logic              i_sqi_req,
    input  logic              i_sqi_wr,
    input  logic [ADDR_W-1:0] i_sqi_addr,
    output logic              o_sqi_ack,
    input  logic              i_sqi_stop,
    output logic              o_sqi_busy,
    output logic [3:0]        o_sqi_rdata,
    output logic              o_sqi_rvld,
    input  logic              i_sqi_racp,
    input  logic [3:0]        i_sqi_wdata,
    input  logic              i_sqi_wvld,
    output logic              o_sqi_wacp,
    output logic              o_sqi_sck,
    output logic              o_sqi_cs,
    output sqi_io_mode_t      o_sqi_io_mode,
    input  logic [3:0]        i_sqi_sio,
    output logic [3:0]        o_sqi_sio
);

    localparam int SR_W      = 8 + ADDR_W;
    localparam int NIB_ADDR  = ADDR_W / 4;
    localparam int MAX_BEATS = sqi_max3(2, NIB_ADDR, DUMMY_NIB);
    localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int DUMMY_LD  = (DUMMY_NIB > 0) ? DUMMY_NIB - 1 : 0;

    sqi_state_t        state_q, state_d;
    logic              phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              wr_q, wr_d;
    logic [3:0]        rdata_q, rdata_d;
    logic              rvld_q, rvld_d;

    always_ff @(posedge i_sqi_gck) begin
        if (!i_sqi_rst_n) begin
            state_q <= SQI_ST_IDLE;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            sr_q    <= '0;
            wr_q    <= 1'b0;
            rdata_q <= 4'h0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        sr_d          = sr_q;
        wr_d          = wr_q;
        rdata_d       = rdata_q;
        rvld_d        = rvld_q;
        o_sqi_ack     = 1'b0;
        o_sqi_wacp    = 1'b0;
        o_sqi_cs      = 1'b1;
        o_sqi_sck     = 1'b0;
        o_sqi_io_mode = SQI_IO_IN;
        o_sqi_sio     = 4'h0;

        // A held nibble survives until accepted, independent of the FSM.
        if (i_sqi_racp) begin
            rvld_d = 1'b0;
        end

        case (state_q)
            SQI_ST_IDLE: begin
                phase_d = 1'b0;
                if (i_sqi_req && i_sqi_rst_n) begin
                    o_sqi_ack = 1'b1;
                    wr_d      = i_sqi_wr;
                    sr_d      = {(i_sqi_wr ? SQI_OP_WRITE : SQI_OP_READ), i_sqi_addr};
                    cnt_d     = CNT_W'(1);
                    state_d   = SQI_ST_CMD;
                end
            end

            SQI_ST_CMD, SQI_ST_ADDR, SQI_ST_DUMMY: begin
                o_sqi_cs  = 1'b0;
                o_sqi_sck = phase_q;
                if (state_q != SQI_ST_DUMMY) begin
                    o_sqi_io_mode = SQI_IO_OUT;
                    o_sqi_sio     = sr_q[SR_W-1 -: 4];
                end
                phase_d = ~phase_q;
                if (phase_q) begin
                    sr_d = sr_q << 4;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (state_q == SQI_ST_CMD) begin
                        state_d = SQI_ST_ADDR;
                        cnt_d   = CNT_W'(NIB_ADDR - 1);
                    end else if (state_q == SQI_ST_ADDR && !wr_q && DUMMY_NIB > 0) begin
                        state_d = SQI_ST_DUMMY;
                        cnt_d   = CNT_W'(DUMMY_LD);
                    end else begin
                        state_d = SQI_ST_DATA;
                    end
                end
            end

            SQI_ST_DATA: begin
                o_sqi_cs  = 1'b0;
                o_sqi_sck = phase_q;
                if (wr_q) begin
                    o_sqi_io_mode = SQI_IO_OUT;
                    if (!phase_q) begin
                        o_sqi_sio = i_sqi_wdata;
                        if (i_sqi_stop) begin
                            state_d = SQI_ST_END;
                        end else if (i_sqi_wvld) begin
                            // Latch the nibble so phase B holds it stable
                            // across the SCK rising edge.
                            o_sqi_wacp             = 1'b1;
                            sr_d[SR_W-1 -: 4]      = i_sqi_wdata;
                            phase_d                = 1'b1;
                        end
                    end else begin
                        o_sqi_sio = sr_q[SR_W-1 -: 4];
                        phase_d   = 1'b0;
                    end
                end else begin
                    if (!phase_q) begin
                        if (i_sqi_stop) begin
                            state_d = SQI_ST_END;
                        end else if (!rvld_q || i_sqi_racp) begin
                            phase_d = 1'b1;
                        end
                    end else begin
                        phase_d = 1'b0;
                        rdata_d = i_sqi_sio;
                        rvld_d  = 1'b1;
                    end
                end
            end

            SQI_ST_END: begin
                phase_d = 1'b0;
                state_d = SQI_ST_IDLE;
            end

            default: begin
                phase_d = 1'b0;
                state_d = SQI_ST_IDLE;
            end
        endcase
    end

    assign o_sqi_busy  = (state_q != SQI_ST_IDLE);
    assign o_sqi_rdata = rdata_q;
    assign o_sqi_rvld  = rvld_q;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Self-checking bench for idli_sqi_ctrl_m: directed read/write/stall/stop/reset
// scenarios, a transaction-level model (expected SIO nibbles per SCK rising
// edge, expected read nibbles per handshake) checked every cycle, plus literal
// timing and sequence expectations.
module tb_idli_sqi_ctrl_m;
    import idli_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         req;
    logic         wr;
    logic [15:0]  addr;
    logic         ack;
    logic         stop;
    logic         busy;
    logic [3:0]   rdata;
    logic         rvld;
    logic         racp;
    logic [3:0]   wdata;
    logic         wvld;
    logic         wacp;
    logic         sck;
    logic         cs;
    sqi_io_mode_t io_mode;
    logic [3:0]   sio_in;
    logic [3:0]   sio_out;

    idli_sqi_ctrl_m #(.ADDR_W(16), .DUMMY_NIB(2)) dut (
        .i_sqi_gck     (clk),
        .i_sqi_rst_n   (rst_n),
        .i_sqi_req     (req),
        .i_sqi_wr      (wr),
        .i_sqi_addr    (addr),
        .o_sqi_ack     (ack),
        .i_sqi_stop    (stop),
        .o_sqi_busy    (busy),
        .o_sqi_rdata   (rdata),
        .o_sqi_rvld    (rvld),
        .i_sqi_racp    (racp),
        .i_sqi_wdata   (wdata),
        .i_sqi_wvld    (wvld),
        .o_sqi_wacp    (wacp),
        .o_sqi_sck     (sck),
        .o_sqi_cs      (cs),
        .o_sqi_io_mode (io_mode),
        .i_sqi_sio     (sio_in),
        .o_sqi_sio     (sio_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Nibbles the SRAM model returns, in data-beat order.
    logic [3:0] rd_pattern [16] = '{4'hA, 4'h5, 4'hC, 4'h3, 4'h9, 4'h6, 4'hE, 4'h1,
                                    4'h7, 4'h8, 4'h2, 4'hD, 4'h4, 4'hB, 4'h0, 4'hF};

    // Transaction model state
    logic       chk_en = 1'b0;
    logic       tx_wr = 1'b0;
    int         edge_cnt = 0;
    int         rd_pops = 0;
    logic [3:0] exp_out [$];
    logic [3:0] exp_rd  [$];
    logic [3:0] seen    [$];
    logic [3:0] lit_q   [$];

    task automatic compare_seen(input string nm);
        check({nm, "_len"}, 32'(seen.size()), 32'(lit_q.size()));
        for (int i = 0; i < lit_q.size() && i < seen.size(); i++)
            check(nm, 32'(seen[i]), 32'(lit_q[i]));
    endtask

    // SRAM model: drives the data nibble while SCK is high in each data beat,
    // and an inverted nibble at all other times so a mistimed sample shows up.
    initial begin
        int   e;
        int   nxt;
        logic ps;
        e = 0;
        ps = 1'b0;
        sio_in = 4'h0;
        forever begin
            @(negedge clk);
            if (cs !== 1'b0) e = 0;
            else if (sck === 1'b1 && ps === 1'b0) e++;
            if (cs === 1'b0 && sck === 1'b1 && e >= 9 && e - 9 < 16) begin
                sio_in = rd_pattern[e - 9];
            end else begin
                nxt = (e >= 8 && e - 8 < 16) ? e - 8 : 0;
                sio_in = 4'hF ^ rd_pattern[nxt];
            end
            ps = sck;
        end
    end

    // Per-cycle compare process
    initial begin
        logic       prev_sck;
        logic       prev_busy;
        logic       hold_prev;
        logic [3:0] prev_rdata;
        logic [3:0] e_nib;
        prev_sck = 1'b0;
        prev_busy = 1'b0;
        hold_prev = 1'b0;
        prev_rdata = 4'h0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (cs === 1'b1) begin
                    check("sck_low_cs_high", 32'(sck), 0);
                    check("io_in_cs_high", 32'(io_mode), 32'(SQI_IO_IN));
                end
                if (busy === 1'b0) check("cs_high_idle", 32'(cs), 1);
                if (prev_sck === 1'b1) check("sck_high_one_cycle", 32'(sck), 0);

                if (ack === 1'b1) begin
                    check("ack_only_from_idle", 32'(prev_busy), 0);
                    exp_out.delete();
                    exp_rd.delete();
                    seen.delete();
                    tx_wr = wr;
                    edge_cnt = 0;
                    rd_pops = 0;
                    exp_out.push_back(4'h0);
                    exp_out.push_back(wr ? 4'h2 : 4'h3);
                    for (int i = 0; i < 4; i++)
                        exp_out.push_back(4'((addr >> (12 - 4 * i)) & 16'hF));
                    if (!wr)
                        for (int i = 0; i < 16; i++) exp_rd.push_back(rd_pattern[i]);
                end

                if (wacp === 1'b1) begin
                    check("wacp_needs_wvld", 32'(wvld), 1);
                    check("wacp_in_write", 32'(tx_wr), 1);
                    check("wacp_sio_eq_wdata", 32'(sio_out), 32'(wdata));
                    check("wacp_sck_low", 32'(sck), 0);
                    exp_out.push_back(wdata);
                end

                if (sck === 1'b1 && prev_sck === 1'b0) begin
                    edge_cnt++;
                    if (tx_wr || edge_cnt <= 6) begin
                        check("edge_io_out", 32'(io_mode), 32'(SQI_IO_OUT));
                        seen.push_back(sio_out);
                        if (exp_out.size() == 0) begin
                            n_total++;
                            $display("FAIL sio_edge: unexpected SCK edge %0d, sio 0x%0h", edge_cnt, sio_out);
                        end else begin
                            e_nib = exp_out.pop_front();
                            check("sio_edge", 32'(sio_out), 32'(e_nib));
                        end
                    end else begin
                        check("edge_io_in", 32'(io_mode), 32'(SQI_IO_IN));
                        if (edge_cnt <= 8) check("dummy_sio_zero", 32'(sio_out), 0);
                    end
                end

                if (hold_prev) begin
                    check("rvld_held", 32'(rvld), 1);
                    check("rdata_stable", 32'(rdata), 32'(prev_rdata));
                end

                if (rvld === 1'b1 && racp === 1'b1) begin
                    if (exp_rd.size() == 0) begin
                        n_total++;
                        $display("FAIL rdata_hs: unexpected nibble 0x%0h", rdata);
                    end else begin
                        e_nib = exp_rd.pop_front();
                        check("rdata_hs", 32'(rdata), 32'(e_nib));
                    end
                    rd_pops++;
                end
            end
            prev_sck   = sck;
            prev_busy  = busy;
            hold_prev  = chk_en && rvld === 1'b1 && racp === 1'b0 && rst_n === 1'b1;
            prev_rdata = rdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = 16'h0; stop = 1'b0;
        racp = 1'b0; wdata = 4'h0; wvld = 1'b0;

        // ---------------- reset ----------------
        for (int i = 0; i < 3; i++) step();
        #2;
        check("rst_cs", 32'(cs), 1);
        check("rst_sck", 32'(sck), 0);
        check("rst_io", 32'(io_mode), 32'(SQI_IO_IN));
        check("rst_busy", 32'(busy), 0);
        check("rst_rvld", 32'(rvld), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_wacp", 32'(wacp), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_sio", 32'(sio_out), 0);
        chk_en = 1'b1;
        rst_n = 1'b1;
        step();

        // ---------------- read burst, stalls, stop with held nibble -------
        step();
        req = 1'b1; wr = 1'b0; addr = 16'h1234; racp = 1'b1;
        #2 check("rd_ack_c0", 32'(ack), 1);
        for (int k = 1; k <= 32; k++) begin
            step();
            req  = (k == 7 || k == 29);
            racp = (k <= 20) || (k == 26) || (k >= 31);
            stop = (k == 28);
            #2;
            if (k == 1)  check("rd_cs_low_c1", 32'(cs), 0);
            if (k == 7)  check("rd_no_ack_addr", 32'(ack), 0);
            if (k == 12) check("rd_io_out_c12", 32'(io_mode), 32'(SQI_IO_OUT));
            if (k == 13) check("rd_io_in_c13", 32'(io_mode), 32'(SQI_IO_IN));
            if (k == 18) check("rd_rvld_c18", 32'(rvld), 0);
            if (k == 19) begin
                check("rd_rvld_c19", 32'(rvld), 1);
                check("rd_rdata_c19", 32'(rdata), 'hA);
            end
            if (k == 21) begin
                check("rd_rvld_c21", 32'(rvld), 1);
                check("rd_rdata_c21", 32'(rdata), 'h5);
            end
            if (k >= 22 && k <= 25) begin
                check("rd_stall_sck", 32'(sck), 0);
                check("rd_stall_rdata", 32'(rdata), 'h5);
            end
            if (k == 29) begin
                check("rd_stop_cs", 32'(cs), 1);
                check("rd_no_ack_end", 32'(ack), 0);
            end
            if (k == 30) begin
                check("rd_idle_busy", 32'(busy), 0);
                check("rd_idle_rvld", 32'(rvld), 1);
                check("rd_idle_rdata", 32'(rdata), 'hC);
            end
            if (k == 32) check("rd_rvld_cleared", 32'(rvld), 0);
        end
        req = 1'b0; racp = 1'b0; stop = 1'b0;
        check("rd_nibbles_delivered", 32'(rd_pops), 3);
        lit_q = '{4'h0, 4'h3, 4'h1, 4'h2, 4'h3, 4'h4};
        compare_seen("rd_cmd_addr_seq");

        // ---------------- write burst with wvld stall ----------------
        step();
        req = 1'b1; wr = 1'b1; addr = 16'hBEEF;
        #2 check("wr_ack_c0", 32'(ack), 1);
        for (int k = 1; k <= 25; k++) begin
            step();
            req   = 1'b0;
            wvld  = (k == 13) || (k >= 18 && k <= 22);
            wdata = (k == 13) ? 4'h1 : (k == 18) ? 4'h2 : (k == 20) ? 4'h3 : 4'h4;
            stop  = (k == 22);
            #2;
            if (k == 12) check("wr_no_wacp_c12", 32'(wacp), 0);
            if (k == 13) check("wr_wacp_c13", 32'(wacp), 1);
            if (k >= 15 && k <= 17) begin
                check("wr_stall_wacp", 32'(wacp), 0);
                check("wr_stall_sck", 32'(sck), 0);
            end
            if (k == 18) check("wr_wacp_c18", 32'(wacp), 1);
            if (k == 20) check("wr_wacp_c20", 32'(wacp), 1);
            if (k == 22) begin
                check("wr_stop_no_wacp", 32'(wacp), 0);
                check("wr_stop_cs_low", 32'(cs), 0);
            end
            if (k == 23) check("wr_stop_cs_high", 32'(cs), 1);
            if (k == 24) check("wr_stop_idle", 32'(busy), 0);
        end
        wvld = 1'b0; stop = 1'b0; wr = 1'b0;
        lit_q = '{4'h0, 4'h2, 4'hB, 4'hE, 4'hE, 4'hF, 4'h1, 4'h2, 4'h3};
        compare_seen("wr_edge_seq");

        // ---------------- reset mid-burst, then a clean read ----------------
        step();
        req = 1'b1; wr = 1'b0; addr = 16'h0F0F;
        #2 check("mr_ack_c0", 32'(ack), 1);
        for (int k = 1; k <= 10; k++) begin
            step();
            rst_n = (k != 7);
            req   = (k == 9);
            racp  = 1'b1;
            #2;
            if (k == 8) begin
                check("mr_cs", 32'(cs), 1);
                check("mr_sck", 32'(sck), 0);
                check("mr_busy", 32'(busy), 0);
                check("mr_io", 32'(io_mode), 32'(SQI_IO_IN));
                check("mr_rvld", 32'(rvld), 0);
            end
            if (k == 9)  check("mr_new_ack", 32'(ack), 1);
            if (k == 10) check("mr_cs_low", 32'(cs), 0);
        end
        req = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 80 && !done; k++) begin
            step();
            racp = 1'b1;
            if (rd_pops >= 2) stop = 1'b1;
            #2;
            if (stop && busy === 1'b0) done = 1'b1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL mr_burst_end: busy still high after 80 cycles");
        end
        stop = 1'b0;
        step();
        step();
        #2;
        check("mr_nibbles_delivered", 32'(rd_pops), 3);
        check("mr_rvld_final", 32'(rvld), 0);
        lit_q = '{4'h0, 4'h3, 4'h0, 4'hF, 4'h0, 4'hF};
        compare_seen("mr_cmd_addr_seq");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
